gshare_predictor: RTL and testbench

Global-history branch direction predictor: hashes the branch PC with a global history register (GHR) to index a table of saturating counters, with separate lookup and resolve interfaces. It is the parametrised successor of the team's BHR + PHT two-level predictor. It adds PC hashing, configurable counter width, and registered one-cycle lookups. Resolved outcomes may arrive later and out of step with lookups. It sits between fetch (lookup) and the branch-resolution stage (update).

---
 rtl/gshare_predictor.sv | 151 +++++++++++++++
 tb/tb_gshare_predictor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch direction predictor with a swept counter table
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   pred_valid_i, pred_pc_i    lookup request and branch PC
//   pred_valid_o               lookup result valid, one cycle after the request
//   pred_taken_o               predicted direction (counter MSB)
//   pred_idx_o                 table index used by the lookup
//   upd_valid_i, upd_idx_i     resolved branch update and its lookup index
//   upd_taken_i                resolved direction
//   upd_pred_i                 direction that was predicted (stats only)
//   busy_o                     table initialisation sweep in progress
//   stat_lookups_o             accepted lookups, saturating (GSHARE_STATS_EN only)
//   stat_mispred_o             mispredicted updates, saturating (GSHARE_STATS_EN only)
//
// Optional feature macro: GSHARE_STATS_EN

module gshare_predictor #(
  parameter int PC_W   = 32,
  parameter int HIST_W = 8,
  parameter int IDX_W  = 8,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid_i,
  input  logic [PC_W-1:0]   pred_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  input  logic              upd_valid_i,
  input  logic [IDX_W-1:0]  upd_idx_i,
  input  logic              upd_taken_i,
  input  logic              upd_pred_i,
  output logic              busy_o
`ifdef GSHARE_STATS_EN
  ,
  output logic [31:0]       stat_lookups_o,
  output logic [31:0]       stat_mispred_o
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] INIT_VAL = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    sweep_q;
  logic [HIST_W-1:0]   ghr_q;
  logic [HIST_W-1:0]   ghr_nxt;
  logic [CTR_W-1:0]    ctr_tbl [DEPTH];

  logic [IDX_W-1:0]    lk_idx;
  logic [CTR_W-1:0]    lk_ctr;
  logic [CTR_W-1:0]    upd_ctr;
  logic [CTR_W-1:0]    upd_ctr_nxt;
  logic                run;

  // PC bits below the word offset and above the index are not part of the hash.
  logic                unused_bits;
  assign unused_bits = ^{upd_pred_i, pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};

  assign run    = (state_q == S_RUN);
  assign lk_idx = pred_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  // Both reads see the table as it was before this edge, which gives
  // read-before-write when a lookup and an update hit the same entry.
  assign lk_ctr  = ctr_tbl[lk_idx];
  assign upd_ctr = ctr_tbl[upd_idx_i];

  generate
    if (HIST_W == 1) begin : g_ghr1
      assign ghr_nxt = upd_taken_i;
    end else begin : g_ghrn
      assign ghr_nxt = {ghr_q[HIST_W-2:0], upd_taken_i};
    end
  endgenerate

  always_comb begin
    upd_ctr_nxt = upd_ctr;
    if (upd_taken_i) begin
      if (upd_ctr != CTR_MAX) upd_ctr_nxt = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_nxt = upd_ctr - CTR_W'(1);
    end
  end

  // Counter storage has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      ctr_tbl[sweep_q] <= INIT_VAL;
    end else if (upd_valid_i) begin
      ctr_tbl[upd_idx_i] <= upd_ctr_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      busy_o       <= 1'b1;
      ghr_q        <= '0;
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_idx_o   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          pred_valid_o <= 1'b0;
          sweep_q      <= sweep_q + IDX_W'(1);
          if (sweep_q == LAST_IDX) begin
            state_q <= S_RUN;
            busy_o  <= 1'b0;
          end
        end
        S_RUN: begin
          pred_valid_o <= pred_valid_i;
          if (pred_valid_i) begin
            pred_taken_o <= lk_ctr[CTR_W-1];
            pred_idx_o   <= lk_idx;
          end
          // History holds resolved outcomes only; lookups never shift it.
          if (upd_valid_i) ghr_q <= ghr_nxt;
        end
        default: begin
          state_q <= S_INIT;
          sweep_q <= '0;
          busy_o  <= 1'b1;
        end
      endcase
    end
  end

`ifdef GSHARE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups_o <= '0;
      stat_mispred_o <= '0;
    end else if (run) begin
      if (pred_valid_i && (stat_lookups_o != 32'hFFFF_FFFF))
        stat_lookups_o <= stat_lookups_o + 32'd1;
      if (upd_valid_i && (upd_pred_i != upd_taken_i) &&
          (stat_mispred_o != 32'hFFFF_FFFF))
        stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor against a table model

module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid_i = 1'b0;
  logic [31:0] pred_pc_i = '0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [7:0]  pred_idx_o;
  logic        upd_valid_i = 1'b0;
  logic [7:0]  upd_idx_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        upd_pred_i = 1'b0;
  logic        busy_o;
`ifdef GSHARE_STATS_EN
  logic [31:0] stat_lookups_o;
  logic [31:0] stat_mispred_o;
`endif

  gshare_predictor #(.PC_W(32), .HIST_W(8), .IDX_W(8), .CTR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .pred_valid_i (pred_valid_i),
    .pred_pc_i    (pred_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_idx_o   (pred_idx_o),
    .upd_valid_i  (upd_valid_i),
    .upd_idx_i    (upd_idx_i),
    .upd_taken_i  (upd_taken_i),
    .upd_pred_i   (upd_pred_i),
    .busy_o       (busy_o)
`ifdef GSHARE_STATS_EN
    ,
    .stat_lookups_o (stat_lookups_o),
    .stat_mispred_o (stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: plain integer counters and an integer history.
  int m_tbl [256];
  int m_ghr;
  int m_lookups;
  int m_mispred;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_tbl[i] = 1;
    m_ghr     = 0;
    m_lookups = 0;
    m_mispred = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ m_ghr) & 255) << 2);
  endfunction

  // One RUN cycle: optional lookup and optional update, checked against the model.
  task automatic cycle(input bit lv, input logic [31:0] pc, input bit uv, input int uidx,
                       input bit ut, input bit up, input string tag);
    int  eidx;
    bit  etaken;
    eidx   = ((pc >> 2) ^ m_ghr) & 255;
    etaken = (m_tbl[eidx] >= 2);
    pred_valid_i = lv;
    pred_pc_i    = pc;
    upd_valid_i  = uv;
    upd_idx_i    = 8'(uidx);
    upd_taken_i  = ut;
    upd_pred_i   = up;
    if (lv) m_lookups++;
    if (uv) begin
      if (ut) m_tbl[uidx] = (m_tbl[uidx] == 3) ? 3 : m_tbl[uidx] + 1;
      else    m_tbl[uidx] = (m_tbl[uidx] == 0) ? 0 : m_tbl[uidx] - 1;
      m_ghr = ((m_ghr << 1) | int'(ut)) & 255;
      if (up != ut) m_mispred++;
    end
    step();
    pred_valid_i = 1'b0;
    upd_valid_i  = 1'b0;
    if (lv) begin
      check({tag, " valid"}, 32'(pred_valid_o), 32'd1);
      check({tag, " idx"},   32'(pred_idx_o),   32'(eidx));
      check({tag, " taken"}, 32'(pred_taken_o), 32'(etaken));
    end
  endtask

  task automatic count_busy(input string tag);
    int n;
    int seen_valid;
    n = 0;
    seen_valid = 0;
    // Requests during INIT must be ignored entirely.
    while (busy_o === 1'b1 && n < 1000) begin
      pred_valid_i = 1'b1;
      pred_pc_i    = $urandom;
      upd_valid_i  = 1'b1;
      upd_idx_i    = 8'($urandom_range(0, 255));
      upd_taken_i  = 1'b1;
      upd_pred_i   = 1'b0;
      step();
      n++;
      if (pred_valid_o === 1'b1) seen_valid++;
    end
    pred_valid_i = 1'b0;
    upd_valid_i  = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 32'd256);
    check({tag, " no valid in init"}, 32'(seen_valid), 32'd0);
    model_reset();
  endtask

  initial begin
    int idx;
    model_reset();

    // Reset state
    step();
    step();
    check("rst pred_valid", 32'(pred_valid_o), 32'd0);
    check("rst pred_taken", 32'(pred_taken_o), 32'd0);
    check("rst pred_idx",   32'(pred_idx_o),   32'd0);
    check("rst busy",       32'(busy_o),       32'd1);
    reset = 1'b0;
    count_busy("init1");
    check("post-init valid", 32'(pred_valid_o), 32'd0);

    // First lookup after init
    cycle(1, 32'h100, 0, 0, 0, 0, "pc100");
    step();
    check("valid one cycle", 32'(pred_valid_o), 32'd0);

    // Two taken updates to 0x43, history becomes 0b11
    cycle(0, 0, 1, 'h43, 1, 1, "upd43a");
    cycle(0, 0, 1, 'h43, 1, 1, "upd43b");
    cycle(1, 32'h100, 0, 0, 0, 0, "pc100b");
    check("ghr idx 43", 32'(pred_idx_o), 32'h43);
    check("idx43 taken", 32'(pred_taken_o), 32'd1);

    // Saturation at idx 0x10
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 'h10, 1, 1, "sat up");
    cycle(0, 0, 1, 'h10, 0, 1, "sat dn1");
    cycle(1, pc_for('h10), 0, 0, 0, 0, "sat ctr2");
    check("sat ctr2 taken", 32'(pred_taken_o), 32'd1);
    cycle(0, 0, 1, 'h10, 0, 1, "sat dn2");
    cycle(0, 0, 1, 'h10, 0, 1, "sat dn3");
    cycle(1, pc_for('h10), 0, 0, 0, 0, "sat ctr0");
    check("sat ctr0 taken", 32'(pred_taken_o), 32'd0);

    // Same-cycle lookup and update on an entry at counter 1
    idx = 'h20;
    check("model idx20 is 1", 32'(m_tbl[idx]), 32'd1);
    cycle(1, pc_for(idx), 1, idx, 1, 0, "rbw same");
    check("rbw old value", 32'(pred_taken_o), 32'd0);
    cycle(1, pc_for(idx), 0, 0, 0, 0, "rbw next");
    check("rbw new value", 32'(pred_taken_o), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit lv, uv, ut, up;
      lv = 1'($urandom);
      uv = 1'($urandom);
      ut = 1'($urandom);
      up = 1'($urandom);
      cycle(lv, (i % 4 == 0) ? pc_for($urandom_range(0, 7)) : $urandom,
            uv, $urandom_range(0, 7) << ($urandom_range(0, 1) * 3), ut, up, "rand");
      if (!lv) check("rand idle valid", 32'(pred_valid_o), 32'd0);
    end

    // Reset mid-RUN, then reset mid-INIT at sweep entry 100
    reset = 1'b1;
    #2;
    check("async rst valid", 32'(pred_valid_o), 32'd0);
    check("async rst busy",  32'(busy_o), 32'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("mid-init busy", 32'(busy_o), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("init2");
    cycle(1, 32'h100, 0, 0, 0, 0, "post-rst pc100");

`ifdef GSHARE_STATS_EN
    check("stat lookups base", stat_lookups_o, 32'(m_lookups));
    for (int i = 0; i < 10; i++) cycle(1, $urandom, 0, 0, 0, 0, "stat lk");
    cycle(0, 0, 1, 5, 1, 0, "stat u1");
    cycle(0, 0, 1, 6, 0, 1, "stat u2");
    cycle(0, 0, 1, 7, 1, 1, "stat u3");
    cycle(0, 0, 1, 8, 1, 0, "stat u4");
    check("stat lookups", stat_lookups_o, 32'(m_lookups));
    check("stat mispred", stat_mispred_o, 32'(m_mispred));
    reset = 1'b1;
    step();
    check("stat lookups rst", stat_lookups_o, 32'd0);
    check("stat mispred rst", stat_mispred_o, 32'd0);
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
